// File: rtl/alu_pkg.sv
//============================================================================
// Module : alu_pkg
// Brief  : Shared ALU opcodes, MIPS op/funct codes and datapath widths.
// Rev    : 1.0
//============================================================================
`default_nettype none

package alu_pkg;

  localparam int NB_DATA        = 32;
  localparam int NB_ALU_OPCODE  = 4;
  localparam int NB_REG_ADDR    = 5;
  localparam int NB_ILLEGAL_CNT = 8;

  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_SLL = 4'b0000;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_ADD = 4'b0001;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_SRL = 4'b0010;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_SRA = 4'b0011;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_AND = 4'b0100;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_OR  = 4'b0101;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_XOR = 4'b0110;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_NOR = 4'b0111;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_SUB = 4'b1101;
  localparam logic [NB_ALU_OPCODE-1:0] C_ALU_SLT = 4'b1111;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ADDIU = 6'b001001;
  localparam logic [5:0] C_OP_SLTI  = 6'b001010;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_XORI  = 6'b001110;
  localparam logic [5:0] C_OP_LUI   = 6'b001111;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  localparam logic [5:0] C_FN_SLL  = 6'b000000;
  localparam logic [5:0] C_FN_SRL  = 6'b000010;
  localparam logic [5:0] C_FN_SRA  = 6'b000011;
  localparam logic [5:0] C_FN_SLLV = 6'b000100;
  localparam logic [5:0] C_FN_SRLV = 6'b000110;
  localparam logic [5:0] C_FN_SRAV = 6'b000111;
  localparam logic [5:0] C_FN_ADD  = 6'b100000;
  localparam logic [5:0] C_FN_ADDU = 6'b100001;
  localparam logic [5:0] C_FN_SUB  = 6'b100010;
  localparam logic [5:0] C_FN_SUBU = 6'b100011;
  localparam logic [5:0] C_FN_AND  = 6'b100100;
  localparam logic [5:0] C_FN_OR   = 6'b100101;
  localparam logic [5:0] C_FN_XOR  = 6'b100110;
  localparam logic [5:0] C_FN_NOR  = 6'b100111;
  localparam logic [5:0] C_FN_SLT  = 6'b101010;

  // Operand source selects driven by the decoder, consumed by the top muxes.
  localparam logic [1:0] C_SEL_A_RS  = 2'd0;
  localparam logic [1:0] C_SEL_A_RT  = 2'd1;
  localparam logic [1:0] C_SEL_A_IMM = 2'd2;

  localparam logic [2:0] C_SEL_B_RT       = 3'd0;
  localparam logic [2:0] C_SEL_B_SHAMT    = 3'd1;
  localparam logic [2:0] C_SEL_B_RS_SHAMT = 3'd2;
  localparam logic [2:0] C_SEL_B_IMM_SEXT = 3'd3;
  localparam logic [2:0] C_SEL_B_IMM_ZEXT = 3'd4;
  localparam logic [2:0] C_SEL_B_SIXTEEN  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/alu_op_decoder.sv
//============================================================================
// Module : alu_op_decoder
// Brief  : Combinational MIPS op/funct to ALU command and operand selects.
// Rev    : 1.0
//============================================================================
`default_nettype none

module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0]               i_op,
  input  logic [5:0]               i_funct,
  input  logic [NB_REG_ADDR-1:0]   i_rt,
  input  logic [NB_REG_ADDR-1:0]   i_rd,
  output logic [NB_ALU_OPCODE-1:0] o_alu_opcode,
  output logic                     o_signed_operation,
  output logic [1:0]               o_sel_a,
  output logic [2:0]               o_sel_b,
  output logic [NB_REG_ADDR-1:0]   o_dest_reg,
  output logic                     o_reg_write,
  output logic                     o_illegal
);

  always_comb begin
    o_alu_opcode       = C_ALU_SLL;
    o_signed_operation = 1'b0;
    o_sel_a            = C_SEL_A_RS;
    o_sel_b            = C_SEL_B_RT;
    o_dest_reg         = '0;
    o_reg_write        = 1'b0;
    o_illegal          = 1'b0;

    case (i_op)
      C_OP_RTYPE: begin
        o_dest_reg  = i_rd;
        o_reg_write = 1'b1;
        case (i_funct)
          C_FN_SLL:  begin o_alu_opcode = C_ALU_SLL; o_sel_a = C_SEL_A_RT; o_sel_b = C_SEL_B_SHAMT; end
          C_FN_SRL:  begin o_alu_opcode = C_ALU_SRL; o_sel_a = C_SEL_A_RT; o_sel_b = C_SEL_B_SHAMT; end
          C_FN_SRA:  begin o_alu_opcode = C_ALU_SRA; o_sel_a = C_SEL_A_RT; o_sel_b = C_SEL_B_SHAMT; end
          C_FN_SLLV: begin o_alu_opcode = C_ALU_SLL; o_sel_a = C_SEL_A_RT; o_sel_b = C_SEL_B_RS_SHAMT; end
          C_FN_SRLV: begin o_alu_opcode = C_ALU_SRL; o_sel_a = C_SEL_A_RT; o_sel_b = C_SEL_B_RS_SHAMT; end
          C_FN_SRAV: begin o_alu_opcode = C_ALU_SRA; o_sel_a = C_SEL_A_RT; o_sel_b = C_SEL_B_RS_SHAMT; end
          C_FN_ADD:  begin o_alu_opcode = C_ALU_ADD; o_signed_operation = 1'b1; end
          C_FN_ADDU: o_alu_opcode = C_ALU_ADD;
          C_FN_SUB:  begin o_alu_opcode = C_ALU_SUB; o_signed_operation = 1'b1; end
          C_FN_SUBU: o_alu_opcode = C_ALU_SUB;
          C_FN_AND:  o_alu_opcode = C_ALU_AND;
          C_FN_OR:   o_alu_opcode = C_ALU_OR;
          C_FN_XOR:  o_alu_opcode = C_ALU_XOR;
          C_FN_NOR:  o_alu_opcode = C_ALU_NOR;
          C_FN_SLT:  o_alu_opcode = C_ALU_SLT;
          default:   o_illegal = 1'b1;
        endcase
      end
      C_OP_ADDI, C_OP_ADDIU, C_OP_SLTI, C_OP_ANDI, C_OP_ORI, C_OP_XORI, C_OP_LUI, C_OP_LW: begin
        o_dest_reg  = i_rt;
        o_reg_write = 1'b1;
        o_sel_b     = C_SEL_B_IMM_SEXT;
        case (i_op)
          C_OP_ADDI:  begin o_alu_opcode = C_ALU_ADD; o_signed_operation = 1'b1; end
          C_OP_SLTI:  o_alu_opcode = C_ALU_SLT;
          C_OP_ANDI:  begin o_alu_opcode = C_ALU_AND; o_sel_b = C_SEL_B_IMM_ZEXT; end
          C_OP_ORI:   begin o_alu_opcode = C_ALU_OR;  o_sel_b = C_SEL_B_IMM_ZEXT; end
          C_OP_XORI:  begin o_alu_opcode = C_ALU_XOR; o_sel_b = C_SEL_B_IMM_ZEXT; end
          C_OP_LUI:   begin o_alu_opcode = C_ALU_SLL; o_sel_a = C_SEL_A_IMM; o_sel_b = C_SEL_B_SIXTEEN; end
          default:    o_alu_opcode = C_ALU_ADD;
        endcase
      end
      C_OP_SW: begin
        o_alu_opcode = C_ALU_ADD;
        o_sel_b      = C_SEL_B_IMM_SEXT;
      end
      C_OP_BEQ, C_OP_BNE: o_alu_opcode = C_ALU_SUB;
      default: o_illegal = 1'b1;
    endcase

    // Undecodable words must not leak partial command fields.
    if (o_illegal) begin
      o_dest_reg  = '0;
      o_reg_write = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
//============================================================================
// Module : alu_issue_stage
// Brief  : ID/EX issue register: decode, operand select, stall/flush, illegal count.
// Rev    : 1.0
//============================================================================
`default_nettype none

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_ALU_OPCODE  = 4,
  parameter int NB_REG_ADDR    = 5,
  parameter int NB_ILLEGAL_CNT = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [31:0]               i_instruction,
  input  logic [NB_DATA-1:0]        i_rs_data,
  input  logic [NB_DATA-1:0]        i_rt_data,
  input  logic                      i_stall,
  input  logic                      i_flush,
  output logic [NB_DATA-1:0]        o_first_operator,
  output logic [NB_DATA-1:0]        o_second_operator,
  output logic [NB_ALU_OPCODE-1:0]  o_alu_opcode,
  output logic                      o_signed_operation,
  output logic [NB_REG_ADDR-1:0]    o_dest_reg,
  output logic                      o_reg_write,
  output logic                      o_valid,
  output logic                      o_illegal,
  output logic [NB_ILLEGAL_CNT-1:0] o_illegal_count
);

  logic [alu_pkg::NB_ALU_OPCODE-1:0] w_alu_opcode;
  logic                              w_signed;
  logic [1:0]                        w_sel_a;
  logic [2:0]                        w_sel_b;
  logic [alu_pkg::NB_REG_ADDR-1:0]   w_dest_reg;
  logic                              w_reg_write;
  logic                              w_illegal;
  logic [NB_DATA-1:0]                w_op_a;
  logic [NB_DATA-1:0]                w_op_b;
  logic [NB_DATA-1:0]                w_imm_sext;
  logic [NB_DATA-1:0]                w_imm_zext;
  logic                              w_unused_rs_field;

  logic [NB_DATA-1:0]        r_first_operator;
  logic [NB_DATA-1:0]        r_second_operator;
  logic [NB_ALU_OPCODE-1:0]  r_alu_opcode;
  logic                      r_signed_operation;
  logic [NB_REG_ADDR-1:0]    r_dest_reg;
  logic                      r_reg_write;
  logic                      r_valid;
  logic                      r_illegal;
  logic [NB_ILLEGAL_CNT-1:0] r_illegal_count;

  // The rs field is consumed upstream as a register-file address.
  assign w_unused_rs_field = ^i_instruction[25:21];

  alu_op_decoder u_decoder (
    .i_op               (i_instruction[31:26]),
    .i_funct            (i_instruction[5:0]),
    .i_rt               (i_instruction[20:16]),
    .i_rd               (i_instruction[15:11]),
    .o_alu_opcode       (w_alu_opcode),
    .o_signed_operation (w_signed),
    .o_sel_a            (w_sel_a),
    .o_sel_b            (w_sel_b),
    .o_dest_reg         (w_dest_reg),
    .o_reg_write        (w_reg_write),
    .o_illegal          (w_illegal)
  );

  assign w_imm_sext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
  assign w_imm_zext = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};

  always_comb begin
    w_op_a = i_rs_data;
    case (w_sel_a)
      C_SEL_A_RT:  w_op_a = i_rt_data;
      C_SEL_A_IMM: w_op_a = w_imm_zext;
      default:     w_op_a = i_rs_data;
    endcase
  end

  always_comb begin
    w_op_b = i_rt_data;
    case (w_sel_b)
      C_SEL_B_SHAMT:    w_op_b = {{(NB_DATA-5){1'b0}}, i_instruction[10:6]};
      C_SEL_B_RS_SHAMT: w_op_b = {{(NB_DATA-5){1'b0}}, i_rs_data[4:0]};
      C_SEL_B_IMM_SEXT: w_op_b = w_imm_sext;
      C_SEL_B_IMM_ZEXT: w_op_b = w_imm_zext;
      C_SEL_B_SIXTEEN:  w_op_b = NB_DATA'(16);
      default:          w_op_b = i_rt_data;
    endcase
  end

  // Priority flush > stall > load; a non-live load (invalid or illegal) is a bubble.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_first_operator   <= '0;
      r_second_operator  <= '0;
      r_alu_opcode       <= '0;
      r_signed_operation <= 1'b0;
      r_dest_reg         <= '0;
      r_reg_write        <= 1'b0;
      r_valid            <= 1'b0;
      r_illegal          <= 1'b0;
      r_illegal_count    <= '0;
    end else if (i_flush || (!i_stall && !(i_valid && !w_illegal))) begin
      r_first_operator   <= '0;
      r_second_operator  <= '0;
      r_alu_opcode       <= '0;
      r_signed_operation <= 1'b0;
      r_dest_reg         <= '0;
      r_reg_write        <= 1'b0;
      r_valid            <= 1'b0;
      r_illegal          <= !i_flush && i_valid && w_illegal;
      if (!i_flush && i_valid && w_illegal && (r_illegal_count != '1)) begin
        r_illegal_count <= r_illegal_count + 1'b1;
      end
    end else if (i_stall) begin
      r_illegal <= 1'b0;
    end else begin
      r_first_operator   <= w_op_a;
      r_second_operator  <= w_op_b;
      r_alu_opcode       <= NB_ALU_OPCODE'(w_alu_opcode);
      r_signed_operation <= w_signed;
      r_dest_reg         <= NB_REG_ADDR'(w_dest_reg);
      r_reg_write        <= w_reg_write;
      r_valid            <= 1'b1;
      r_illegal          <= 1'b0;
    end
  end

  assign o_first_operator   = r_first_operator;
  assign o_second_operator  = r_second_operator;
  assign o_alu_opcode       = r_alu_opcode;
  assign o_signed_operation = r_signed_operation;
  assign o_dest_reg         = r_dest_reg;
  assign o_reg_write        = r_reg_write;
  assign o_valid            = r_valid;
  assign o_illegal          = r_illegal;
  assign o_illegal_count    = r_illegal_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//============================================================================
// Module : tb_alu_issue_stage
// Brief  : Randomized bench for alu_issue_stage against a behavioural model.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, stall, flush;
  logic [31:0] instr, rs_d, rt_d;

  logic [31:0] o_a, o_b;
  logic [3:0]  o_opc;
  logic        o_sgn, o_rw, o_vld, o_ill;
  logic [4:0]  o_dest;
  logic [7:0]  o_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_valid            (valid),
    .i_instruction      (instr),
    .i_rs_data          (rs_d),
    .i_rt_data          (rt_d),
    .i_stall            (stall),
    .i_flush            (flush),
    .o_first_operator   (o_a),
    .o_second_operator  (o_b),
    .o_alu_opcode       (o_opc),
    .o_signed_operation (o_sgn),
    .o_dest_reg         (o_dest),
    .o_reg_write        (o_rw),
    .o_valid            (o_vld),
    .o_illegal          (o_ill),
    .o_illegal_count    (o_cnt)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
    logic        sgn;
    logic [4:0]  dest;
    logic        rw;
    logic        vld;
    logic        ill;
    logic [7:0]  cnt;
  } out_t;

  // Spec-level decode: returns the issued command, or legal=0.
  function automatic out_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                      input logic [31:0] rt, output logic legal);
    out_t d;
    logic [31:0] se, ze;
    d = '0;
    legal = 1'b1;
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    d.vld = 1'b1;
    d.a = rs;
    d.b = rt;
    case (ins[31:26])
      6'h00: begin
        d.dest = ins[15:11];
        d.rw = 1'b1;
        case (ins[5:0])
          6'h00: begin d.opc = 4'h0; d.a = rt; d.b = {27'h0, ins[10:6]}; end
          6'h02: begin d.opc = 4'h2; d.a = rt; d.b = {27'h0, ins[10:6]}; end
          6'h03: begin d.opc = 4'h3; d.a = rt; d.b = {27'h0, ins[10:6]}; end
          6'h04: begin d.opc = 4'h0; d.a = rt; d.b = {27'h0, rs[4:0]}; end
          6'h06: begin d.opc = 4'h2; d.a = rt; d.b = {27'h0, rs[4:0]}; end
          6'h07: begin d.opc = 4'h3; d.a = rt; d.b = {27'h0, rs[4:0]}; end
          6'h20: begin d.opc = 4'h1; d.sgn = 1'b1; end
          6'h21: d.opc = 4'h1;
          6'h22: begin d.opc = 4'hD; d.sgn = 1'b1; end
          6'h23: d.opc = 4'hD;
          6'h24: d.opc = 4'h4;
          6'h25: d.opc = 4'h5;
          6'h26: d.opc = 4'h6;
          6'h27: d.opc = 4'h7;
          6'h2A: d.opc = 4'hF;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin d.opc = 4'h1; d.sgn = 1'b1; d.b = se; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h09: begin d.opc = 4'h1; d.b = se; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h0A: begin d.opc = 4'hF; d.b = se; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h0C: begin d.opc = 4'h4; d.b = ze; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h0D: begin d.opc = 4'h5; d.b = ze; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h0E: begin d.opc = 4'h6; d.b = ze; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h0F: begin d.opc = 4'h0; d.a = ze; d.b = 32'd16; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h23: begin d.opc = 4'h1; d.b = se; d.dest = ins[20:16]; d.rw = 1'b1; end
      6'h2B: begin d.opc = 4'h1; d.b = se; end
      6'h04, 6'h05: d.opc = 4'hD;
      default: legal = 1'b0;
    endcase
    if (!legal) d = '0;
    return d;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state and per-cycle compare.
  out_t m;
  logic checking = 1'b0;

  always begin
    out_t d;
    logic lg;
    @(posedge clk);
    if (rst) begin
      m = '0;
    end else begin
      d = ref_decode(instr, rs_d, rt_d, lg);
      if (flush) begin
        d.cnt = m.cnt;
        m = d;
        m = '0;
        m.cnt = d.cnt;
      end else if (stall) begin
        m.ill = 1'b0;
      end else if (valid && lg) begin
        d.cnt = m.cnt;
        m = d;
      end else begin
        d = '0;
        d.cnt = m.cnt;
        if (valid) begin
          d.ill = 1'b1;
          if (d.cnt != 8'hFF) d.cnt = d.cnt + 8'd1;
        end
        m = d;
      end
    end
    #1;
    if (checking)
      chk("cycle", 128'({o_a, o_b, o_opc, o_sgn, o_dest, o_rw, o_vld, o_ill, o_cnt}), 128'(m));
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st, input logic fl);
    @(negedge clk);
    valid = v; instr = ins; rs_d = rs; rt_d = rt; stall = st; flush = fl;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [12];
    logic [5:0] fns [16];
    logic [31:0] w;
    int k;
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F};
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01};
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k >= 12) w[31:26] = 6'h05;
    else w[31:26] = ops[k];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    rst = 1'b1; valid = 0; instr = 0; rs_d = 0; rt_d = 0; stall = 0; flush = 0;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", 128'(o_vld), 128'(0));
    chk("reset_count", 128'(o_cnt), 128'(0));
    @(negedge clk) rst = 1'b0;

    // ADD $3,$1,$2
    drive(1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'hFFFFFFFF, 32'h2, 0, 0);
    after_edge();
    chk("add_cmd", 128'({o_opc, o_sgn, o_dest, o_rw, o_vld}), 128'({4'h1, 1'b1, 5'd3, 1'b1, 1'b1}));
    chk("add_ops", 128'({o_a, o_b}), 128'({32'hFFFFFFFF, 32'h2}));

    drive(1, {6'h0F, 5'd0, 5'd5, 16'h1234}, $urandom, $urandom, 0, 0);
    after_edge();
    chk("lui", 128'({o_opc, o_a, o_b, o_dest}), 128'({4'h0, 32'h1234, 32'd16, 5'd5}));

    drive(1, {6'h0C, 5'd1, 5'd6, 16'h8000}, $urandom, $urandom, 0, 0);
    after_edge();
    chk("andi_zext", 128'({o_opc, o_b}), 128'({4'h4, 32'h00008000}));

    drive(1, {6'h08, 5'd1, 5'd6, 16'h8000}, $urandom, $urandom, 0, 0);
    after_edge();
    chk("addi_sext", 128'({o_opc, o_sgn, o_b}), 128'({4'h1, 1'b1, 32'hFFFF8000}));

    // SLT $4,$1,$2 then three stalled cycles
    drive(1, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h2A}, 32'd5, 32'd7, 0, 0);
    after_edge();
    chk("slt", 128'({o_opc, o_a, o_b, o_dest, o_vld}), 128'({4'hF, 32'd5, 32'd7, 5'd4, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_instr(), $urandom, $urandom, 1, 0);
      after_edge();
      chk("stall_hold", 128'({o_opc, o_a, o_b, o_dest, o_vld}), 128'({4'hF, 32'd5, 32'd7, 5'd4, 1'b1}));
    end
    drive(1, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 32'd9, 32'd9, 1, 1);
    after_edge();
    chk("stall_flush_bubble", 128'({o_vld, o_rw, o_opc, o_a, o_b}), 128'(0));

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
    end

    // Illegal-word saturation
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 300; i++) drive(1, {6'h3F, 26'($urandom)}, $urandom, $urandom, 0, 0);
    after_edge();
    chk("illegal_sat", 128'({o_ill, o_cnt}), 128'({1'b1, 8'hFF}));
    drive(1, {6'h3F, 26'h0}, 0, 0, 1, 0);
    after_edge();
    chk("illegal_stalled", 128'({o_ill, o_cnt, o_vld}), 128'({1'b0, 8'hFF, 1'b0}));

    // Asynchronous reset mid-cycle
    drive(1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h11, 32'h22, 0, 0);
    after_edge();
    #1 rst = 1'b1;
    #1;
    chk("async_reset", 128'({o_a, o_b, o_opc, o_sgn, o_dest, o_rw, o_vld, o_ill, o_cnt}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid = 1; instr = {6'h04, 5'd1, 5'd2, 16'h0010}; rs_d = $urandom; rt_d = $urandom;
    stall = 0; flush = 0;
    after_edge();
    chk("beq", 128'({o_opc, o_sgn, o_rw, o_vld, o_dest}), 128'({4'hD, 1'b0, 1'b0, 1'b1, 5'd0}));
    drive(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("invalid_bubble", 128'({o_vld, o_opc}), 128'(0));

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue register for the MIPS datapath. Accepts an instruction word plus register-file read data and produces, one cycle later, the registered operand pair, 4-bit ALU opcode and signed-operation flag the ALU consumes. It supplies the ALU's decoded command interface and holds the ID/EX boundary: stall, flush, destination tracking and illegal-instruction reporting.

## Interface
- NB_DATA, 32: datapath width.
- NB_ALU_OPCODE, 4: ALU opcode width.
- NB_REG_ADDR, 5: register address width.
- NB_ILLEGAL_CNT, 8: illegal-instruction counter width.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  instruction and read data valid this cycle.
- i_instruction  in  32  MIPS instruction word.
- i_rs_data  in  NB_DATA  register file data for rs.
- i_rt_data  in  NB_DATA  register file data for rt.
- i_stall  in  1  hold all outputs.
- i_flush  in  1  insert bubble.
- o_first_operator  out  NB_DATA  ALU operand A.
- o_second_operator  out  NB_DATA  ALU operand B.
- o_alu_opcode  out  NB_ALU_OPCODE  ALU command.
- o_signed_operation  out  1  signed add/sub select.
- o_dest_reg  out  NB_REG_ADDR  write-back register.
- o_reg_write  out  1  result is written back.
- o_valid  out  1  outputs hold a live instruction.
- o_illegal  out  1  pulse: the registered instruction was undecodable.
- o_illegal_count  out  NB_ILLEGAL_CNT  saturating count of illegal instructions.

## Operation
- R-type (op 000000), funct -> opcode/operands:
  - SLL 000000 -> 0000, A=rt, B=zero-extended shamt. SRL 000010 -> 0010. SRA 000011 -> 0011 (same operands).
  - SLLV 000100, SRLV 000110, SRAV 000111 -> same codes, A=rt, B=rs[4:0] zero-extended.
  - ADD 100000 / ADDU 100001 -> 0001, signed=1/0. SUB 100010 / SUBU 100011 -> 1101, signed=1/0.
  - AND 100100 -> 0100, OR 100101 -> 0101, XOR 100110 -> 0110, NOR 100111 -> 0111, SLT 101010 -> 1111.
  - A=rs and B=rt unless listed otherwise; dest=rd; reg_write=1.
- I-type, A=rs, dest=rt, reg_write=1:
  - ADDI 001000 -> ADD signed, B=sign-extended imm. ADDIU 001001 -> ADD unsigned, B=sign-extended imm. SLTI 001010 -> SLT, B=sign-extended imm.
  - ANDI 001100, ORI 001101, XORI 001110 -> AND/OR/XOR, B=zero-extended imm.
  - LUI 001111 -> SLL, A=zero-extended imm, B=16.
- LW 100011 -> ADD unsigned, B=sign-extended imm, dest=rt, reg_write=1. SW 101011 -> same, reg_write=0, dest=0.
- BEQ 000100 / BNE 000101 -> SUB unsigned, A=rs, B=rt, reg_write=0, dest=0.
- Any other op/funct is illegal: outputs load as a bubble, o_illegal=1 for one cycle, counter increments and saturates at all-ones.
- signed_operation=0 for every command except ADD, SUB and ADDI.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Reset (async, immediate): all outputs 0, o_valid=0, counter=0.
- Bubble: o_valid=0, reg_write=0, dest=0, opcode=0000, operands=0, signed=0.
- Per edge, priority flush > stall > load.
  - Flush loads a bubble regardless of i_stall and i_valid.
  - Stall holds every output, including o_valid; o_illegal is forced to 0 during a hold.
  - Load with i_valid=0 loads a bubble.
- Illegal detection only when loaded with i_valid=1 and no stall or flush.
- Reset mid-stall clears state; the first post-reset edge behaves as a normal load.

## Structure
- Shared package alu_pkg: the ten ALU opcode constants, MIPS op and funct constants, and width parameters; also used by alu.
- Combinational sub-module alu_op_decoder: instruction -> {opcode, signed, operand selects, dest, reg_write, illegal}. The top holds the operand muxes, the pipeline register and the counter.

## Test plan
- ADD $3,$1,$2 with rs=0xFFFFFFFF, rt=0x00000002, i_valid=1 -> next cycle: opcode 0001, signed=1, A=0xFFFFFFFF, B=0x2, dest=3, reg_write=1, valid=1.
- LUI $5,0x1234 -> SLL, A=0x00001234, B=16, dest=5. ANDI with imm 0x8000 -> B=0x00008000. ADDI with imm 0x8000 -> B=0xFFFF8000.
- Assert i_stall for 3 cycles after an SLT -> outputs unchanged for 3 cycles. Assert stall+flush together -> bubble on the next cycle.
- Feed 300 illegal words (op 111111) -> o_illegal pulses once per word, count saturates at 255. A stalled illegal word produces no extra pulse.
- Assert i_reset asynchronously mid-cycle while valid=1 -> all outputs 0 before the next edge. Deassert, send BEQ -> opcode 1101, signed=0, reg_write=0.
